// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: bundles the four master ports and the shared slave port of the arbiter
interface wb_rr_arbiter_if #(parameter int adr_width = 32) ();
  logic [3:0]             m_cyc_i;
  logic [3:0]             m_stb_i;
  logic [3:0]             m_we_i;
  logic [4*adr_width-1:0] m_adr_i;
  logic [127:0]           m_dat_i;
  logic [15:0]            m_sel_i;
  logic [31:0]            m_dat_o;
  logic [3:0]             m_ack_o;
  logic [3:0]             m_err_o;
  logic                   s_cyc_o;
  logic                   s_stb_o;
  logic                   s_we_o;
  logic [adr_width-1:0]   s_adr_o;
  logic [31:0]            s_dat_o;
  logic [3:0]             s_sel_o;
  logic [31:0]            s_dat_i;
  logic                   s_ack_i;
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: four-master Wishbone round-robin arbiter with per-transfer watchdog
module wb_rr_arbiter #(
  parameter int adr_width      = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_rr_arbiter_if.slave        bus,
  output logic [3:0]            grant_o,
  output logic                  busy_o
);
  typedef enum logic {IDLE, OWNED} state_t;
  localparam logic [15:0] tmax = timeout_cycles == 0 ? 16'd0 : 16'(timeout_cycles - 1);
  state_t      state_q, state_d;
  logic [1:0]  g_q, g_d, last_q, last_d, c;
  logic [15:0] cnt_q, cnt_d;
  logic        owned, stb_raw, to;
  assign owned   = state_q == OWNED;
  assign stb_raw = owned & bus.m_stb_i[g_q] & bus.m_cyc_i[g_q];
  assign to      = (timeout_cycles != 0) && stb_raw && !bus.s_ack_i && cnt_q == tmax;
  assign grant_o = 4'(owned) << g_q;
  assign busy_o  = owned;
  assign bus.s_cyc_o = owned & bus.m_cyc_i[g_q];
  assign bus.s_stb_o = stb_raw & ~to;
  assign bus.s_we_o  = owned & bus.m_we_i[g_q];
  assign bus.s_adr_o = owned ? bus.m_adr_i[g_q*adr_width +: adr_width] : '0;
  assign bus.s_dat_o = owned ? bus.m_dat_i[g_q*32 +: 32] : '0;
  assign bus.s_sel_o = owned ? bus.m_sel_i[g_q*4 +: 4] : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = 4'(owned & bus.s_ack_i) << g_q;
  assign bus.m_err_o = 4'(to) << g_q;
  // next grant search, release on CYC drop, and wait-state counting
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = '0;
    c       = '0;
    if (!owned) begin
      for (int k = 4; k >= 1; k--) begin
        c = last_q + 2'(k);
        if (bus.m_cyc_i[c]) begin
          g_d     = c;
          state_d = OWNED;
        end
      end
    end else if (!bus.m_cyc_i[g_q]) begin
      state_d = IDLE;
      last_d  = g_q;
    end else if (stb_raw && !bus.s_ack_i && !to) begin
      cnt_d = cnt_q + 16'd1;
    end
  end
  // state, grant index, last-served pointer and watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Four-master Wishbone round-robin arbiter that shares one Wishbone master port, such as the crossbar master input, among CPU instruction/data ports and future DMA/bootloader masters.
- Grant is held for the whole cycle (CYC high), so bursts and read-modify-write sequences stay atomic.
- A per-transfer watchdog terminates stalled transfers with ERR so a hung slave cannot lock the SoC.

Parameters:
adr_width, 32, address width per master
timeout_cycles, 255, max wait states per transfer before ERR; 0 disables the watchdog; legal 0..65535

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
m_cyc_i  in  4  master CYC, bit i = master i
m_stb_i  in  4  master STB
m_we_i  in  4  master WE
m_adr_i  in  4*adr_width  master addresses, master i at [i*adr_width +: adr_width]
m_dat_i  in  128  master write data, master i at [i*32 +: 32]
m_sel_i  in  16  master byte selects, master i at [i*4 +: 4]
m_dat_o  out  32  read data, broadcast to all masters
m_ack_o  out  4  ACK, only the granted bit can be set
m_err_o  out  4  ERR, only the granted bit can be set
s_cyc_o  out  1  shared-port CYC
s_stb_o  out  1  shared-port STB
s_we_o  out  1  shared-port WE
s_adr_o  out  adr_width  shared-port address
s_dat_o  out  32  shared-port write data
s_sel_o  out  4  shared-port byte selects
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave ACK
grant_o  out  4  one-hot current grant; 0 when idle
busy_o  out  1  high while any grant is held

Behaviour:
- Reset (rst low, asynchronous):
  - grant_o=0, busy_o=0, state IDLE.
  - Last-served pointer=3, so master 0 has first priority.
  - Watchdog counter=0. All s_* control outputs and m_ack_o/m_err_o are 0.
- State machine: IDLE, OWNED.
  - IDLE: if any m_cyc_i is set, register a one-hot grant on the next rising edge and go to OWNED. Grant latency is one cycle from CYC to grant_o. In IDLE all s_* controls are 0.
  - OWNED, forwarding (combinational from the grant register and the granted master's inputs): s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g]&m_cyc_i[g], and we/adr/dat/sel from master g. m_ack_o[g]=s_ack_i. m_dat_o=s_dat_i always.
  - OWNED, release: when m_cyc_i[g] falls, grant drops on the next edge and the state returns to IDLE. The last-served pointer is set to g. There is a mandatory one-cycle bubble, so no back-to-back re-grant in the same cycle.
- Round-robin: search order is (last+1)%4, (last+2)%4, ... The first master with CYC set wins. Requests arriving while OWNED wait; they are never dropped.
- Inputs of non-granted masters are ignored, and their ack/err stay 0.
- Watchdog (timeout_cycles>0):
  - 16-bit counter increments every OWNED cycle with s_stb_o=1 and s_ack_i=0. It clears on s_ack_i, on STB low, and on entering OWNED.
  - When the count equals timeout_cycles, m_err_o[g] pulses for exactly 1 cycle. In that cycle s_stb_o is forced to 0 and the counter clears.
  - Grant is kept until the master drops CYC.
  - If s_ack_i and the timeout coincide, ACK wins and no ERR is raised.
- ACK and CYC dropping in the same cycle: the ACK is passed through, then release proceeds normally.
- Reset mid-transfer: all outputs go to their reset values immediately (asynchronously), and the pointer returns to 3.
- busy_o = (state==OWNED).

Test Plan:
- Single master: m_cyc_i=4'b0010, read to 0x20000004, slave acks after 2 waits with 0xDEADBEEF. Required: grant_o=0010 one cycle after CYC, m_ack_o=0010 for one cycle, m_dat_o=0xDEADBEEF. Grant drops one cycle after CYC falls.
- Simultaneous request, all four masters holding CYC from reset with single-beat cycles: grant order is 0,1,2,3,0, with exactly one idle bubble between grants.
- Atomic hold: master 1 holds CYC across 3 STB beats while master 0 requests. Required: grant_o stays 0010 throughout, m_ack_o[0] stays 0, and master 0 is granted only after master 1 releases.
- Timeout, timeout_cycles=4, slave never acks: m_err_o[g] pulses exactly on the 4th wait cycle, s_stb_o=0 in that cycle, no ACK is issued, and the grant is released after CYC drops.
- ACK/timeout coincidence, timeout_cycles=3: s_ack_i arrives on the 3rd wait cycle. Required: ACK is delivered and m_err_o stays 0.
- Asynchronous reset asserted mid-burst, between clock edges: grant_o, s_cyc_o and busy_o go to 0 without waiting for an edge. After reset releases with all masters requesting, master 0 is granted first.
